// File: rtl/fibonacci_checker.sv
// fibonacci_checker: valid/ready sink that checks a stream against 1,1,2,3,5,...
// Optional wrap detection is built when FIB_CHECK_WRAP_DETECT_EN is defined.
module fibonacci_checker #(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic [DATA_WIDTH-1:0]  din,
   input  logic                   din_valid,
   output logic                   din_ready,
   output logic                   match,
   output logic                   mismatch,
   output logic                   error,
   output logic [COUNT_WIDTH-1:0] term_count,
   output logic [DATA_WIDTH-1:0]  err_expected,
   output logic [DATA_WIDTH-1:0]  err_received,
   output logic                   wrap
);

   typedef enum logic [1:0] {
      INIT,
      CHECK,
      FAIL
   } state_t;

   localparam logic [DATA_WIDTH-1:0] ONE_D =
      {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [COUNT_WIDTH-1:0] ONE_C =
      {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

   state_t                 state, state_nx;
   logic [DATA_WIDTH-1:0]  exp_cur, exp_prev;
   logic [DATA_WIDTH-1:0]  cur_nx, prev_nx;
   logic [DATA_WIDTH-1:0]  eexp_nx, ercv_nx;
   logic [DATA_WIDTH-1:0]  sum;
   logic [COUNT_WIDTH-1:0] cnt_nx;
   logic                   match_nx, mismatch_nx;
   logic                   accept, hit, advance;

   assign din_ready = (state != INIT) & ~clear & ~reset;
   assign accept    = din_valid & din_ready;
   assign hit       = (din == exp_cur);
   assign advance   = (state == CHECK) & accept & hit;
   assign error     = (state == FAIL);

`ifdef FIB_CHECK_WRAP_DETECT_EN
   logic carry;
   logic wrap_q;

   assign {carry, sum} = {1'b0, exp_cur} + {1'b0, exp_prev};
   assign wrap = wrap_q;

   // sticky: one carry anywhere in the run is enough to flag it
   always_ff @(posedge clk) begin
      if (reset | clear)
         wrap_q <= 1'b0;
      else if (advance & carry)
         wrap_q <= 1'b1;
   end
`else
   assign sum  = exp_cur + exp_prev;
   assign wrap = 1'b0;
`endif

   always_comb begin
      state_nx    = state;
      cur_nx      = exp_cur;
      prev_nx     = exp_prev;
      cnt_nx      = term_count;
      eexp_nx     = err_expected;
      ercv_nx     = err_received;
      match_nx    = 1'b0;
      mismatch_nx = 1'b0;
      unique case (state)
         INIT: state_nx = CHECK;
         CHECK: begin
            if (accept) begin
               if (hit) begin
                  match_nx = 1'b1;
                  prev_nx  = exp_cur;
                  cur_nx   = sum;
                  if (term_count != CNT_MAX)
                     cnt_nx = term_count + ONE_C;
               end else begin
                  mismatch_nx = 1'b1;
                  eexp_nx     = exp_cur;
                  ercv_nx     = din;
                  state_nx    = FAIL;
               end
            end
         end
         FAIL: state_nx = FAIL;
         default: state_nx = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset | clear) begin
         state        <= INIT;
         exp_cur      <= ONE_D;
         exp_prev     <= '0;
         term_count   <= '0;
         err_expected <= '0;
         err_received <= '0;
         match        <= 1'b0;
         mismatch     <= 1'b0;
      end else begin
         state        <= state_nx;
         exp_cur      <= cur_nx;
         exp_prev     <= prev_nx;
         term_count   <= cnt_nx;
         err_expected <= eexp_nx;
         err_received <= ercv_nx;
         match        <= match_nx;
         mismatch     <= mismatch_nx;
      end
   end

endmodule

// File: tb/tb_fibonacci_checker.sv
// tb_fibonacci_checker: drives a 32-bit and an 8-bit/4-bit checker with one
// stream and scores every cycle against a Fibonacci-sequence reference.
module tb_fibonacci_checker;

   localparam bit WRAP_EN =
`ifdef FIB_CHECK_WRAP_DETECT_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic        din_valid = 1'b0;
   logic [31:0] din = '0;

   logic        a_rdy, a_m, a_mm, a_err, a_w;
   logic [15:0] a_cnt;
   logic [31:0] a_ee, a_er;
   logic        b_rdy, b_m, b_mm, b_err, b_w;
   logic [3:0]  b_cnt;
   logic [7:0]  b_ee, b_er;

   always #5 clk = ~clk;

   fibonacci_checker dut_a (
      .clk(clk), .reset(reset), .clear(clear),
      .din(din), .din_valid(din_valid), .din_ready(a_rdy),
      .match(a_m), .mismatch(a_mm), .error(a_err),
      .term_count(a_cnt), .err_expected(a_ee),
      .err_received(a_er), .wrap(a_w)
   );

   fibonacci_checker #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut_b (
      .clk(clk), .reset(reset), .clear(clear),
      .din(din[7:0]), .din_valid(din_valid), .din_ready(b_rdy),
      .match(b_m), .mismatch(b_mm), .error(b_err),
      .term_count(b_cnt), .err_expected(b_ee),
      .err_received(b_er), .wrap(b_w)
   );

   typedef struct packed {
      logic        m;
      logic        mm;
      logic        er;
      logic        w;
      logic [31:0] cnt;
      logic [31:0] ee;
      logic [31:0] rv;
   } rec_t;

   rec_t qa[$];
   rec_t qb[$];
   int   checks = 0;
   int   errors = 0;
   int   mcnt[2];

   longint unsigned fibv[0:90];
   longint unsigned mask[2] = '{64'hFFFF_FFFF, 64'hFF};
   longint unsigned cmax[2] = '{65535, 15};

   int              mn[2];
   bit              mfail[2];
   bit              mw[2];
   bit              mpm[2];
   bit              mpmm[2];
   longint unsigned mcv[2];
   longint unsigned mee[2];
   longint unsigned mer[2];
   bit              init_m = 1'b1;

   // reference: n-th term of the sequence, truncated to the instance width
   function automatic void step(int i, bit rs, bit acc,
                                longint unsigned d);
      longint unsigned e, p, dv;
      mpm[i]  = 1'b0;
      mpmm[i] = 1'b0;
      if (rs) begin
         mn[i] = 0; mfail[i] = 0; mw[i] = 0;
         mcv[i] = 0; mee[i] = 0; mer[i] = 0;
      end else if (acc && !mfail[i]) begin
         e  = fibv[mn[i]] & mask[i];
         p  = (mn[i] == 0) ? 0 : (fibv[mn[i]-1] & mask[i]);
         dv = d & mask[i];
         if (dv == e) begin
            mpm[i] = 1'b1;
            if (mcv[i] < cmax[i]) mcv[i] = mcv[i] + 1;
            if (WRAP_EN && (e + p > mask[i])) mw[i] = 1'b1;
            mn[i] = mn[i] + 1;
         end else begin
            mpmm[i]  = 1'b1;
            mee[i]   = e;
            mer[i]   = dv;
            mfail[i] = 1'b1;
         end
      end
   endfunction

   function automatic rec_t mkrec(int i);
      rec_t r;
      r     = '0;
      r.m   = mpm[i];
      r.mm  = mpmm[i];
      r.er  = mfail[i];
      r.w   = mw[i];
      r.cnt = mcv[i][31:0];
      r.ee  = mee[i][31:0];
      r.rv  = mer[i][31:0];
      return r;
   endfunction

   function automatic void cmp(string n, rec_t ac, rec_t ex);
      checks++;
      if (ac !== ex) begin
         errors++;
         $display("FAIL %s @%0t got m=%0b mm=%0b err=%0b w=%0b cnt=%0d ee=%0h rv=%0h expected m=%0b mm=%0b err=%0b w=%0b cnt=%0d ee=%0h rv=%0h",
                  n, $time, ac.m, ac.mm, ac.er, ac.w, ac.cnt, ac.ee, ac.rv,
                  ex.m, ex.mm, ex.er, ex.w, ex.cnt, ex.ee, ex.rv);
      end
   endfunction

   task automatic chk(string n, longint unsigned act,
                      longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", n, act, exp);
      end
   endtask

   task automatic drive(bit v, logic [31:0] d, bit clr = 0, bit rst = 0);
      bit er, acc;
      @(negedge clk);
      din = d; din_valid = v; clear = clr; reset = rst;
      #1;
      er = !init_m && !clr && !rst;
      chk("ready_a", a_rdy, er);
      chk("ready_b", b_rdy, er);
      acc = v && er;
      step(0, clr | rst, acc, d);
      step(1, clr | rst, acc, d);
      init_m = clr | rst;
      qa.push_back(mkrec(0));
      qb.push_back(mkrec(1));
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic restart();
      drive(0, 0, 0, 1);
      mcnt[0] = 0;
      mcnt[1] = 0;
   endtask

   rec_t ma, mb, ea, eb;

   always @(posedge clk) begin
      #1;
      ma = {a_m, a_mm, a_err, a_w, 16'h0, a_cnt, a_ee, a_er};
      mb = {b_m, b_mm, b_err, b_w, 28'h0, b_cnt,
            24'h0, b_ee, 24'h0, b_er};
      if (qa.size() > 0) begin
         ea = qa.pop_front();
         cmp("cycle_a", ma, ea);
      end
      if (qb.size() > 0) begin
         eb = qb.pop_front();
         cmp("cycle_b", mb, eb);
      end
      if (a_m) mcnt[0]++;
      if (b_m) mcnt[1]++;
   end

   initial begin
      int idx;
      bit clr;
      logic [31:0] d;
      fibv[0] = 1;
      fibv[1] = 1;
      for (int i = 2; i <= 90; i++) fibv[i] = fibv[i-1] + fibv[i-2];

      // reset values and back-to-back correct stream
      restart();
      settle();
      chk("rst_cnt", a_cnt, 0);
      chk("rst_err", a_err, 0);
      chk("rst_w", b_w, 0);
      drive(1, 1);
      for (int k = 0; k < 7; k++) drive(1, fibv[k][31:0]);
      drive(0, 0);
      settle();
      chk("t1_matches", mcnt[0], 7);
      chk("t1_cnt", a_cnt, 7);
      chk("t1_err", a_err, 0);

      // mismatch on 4th sample, 5th drained
      restart();
      drive(0, 0);
      drive(1, 1); drive(1, 1); drive(1, 2); drive(1, 4); drive(1, 5);
      drive(0, 0);
      settle();
      chk("t2_matches", mcnt[0], 3);
      chk("t2_err", a_err, 1);
      chk("t2_ee", a_ee, 3);
      chk("t2_er", a_er, 4);
      chk("t2_cnt", a_cnt, 3);
      chk("t2_ee_b", b_ee, 3);

      // gapped stream, then clear with valid high
      restart();
      drive(0, 0);
      drive(1, 1); drive(0, 0); drive(1, 1); drive(0, 0);
      drive(1, 2); drive(0, 0);
      drive(1, 3, 1, 0);
      mcnt[0] = 0;
      drive(1, 1); drive(1, 1); drive(1, 1);
      drive(0, 0);
      settle();
      chk("t3_matches", mcnt[0], 2);
      chk("t3_cnt", a_cnt, 2);

      // 8-bit wrap past 233
      restart();
      drive(0, 0);
      for (int k = 0; k < 13; k++) drive(1, fibv[k][31:0]);
      drive(1, 121);
      drive(0, 0);
      settle();
      chk("t4_matches_b", mcnt[1], 14);
      chk("t4_wrap_b", b_w, WRAP_EN);
      chk("t4_wrap_a", a_w, 0);
      chk("t4_err_a", a_err, 1);
      drive(0, 0);
      settle();
      chk("t4_wrap_hold", b_w, WRAP_EN);

      // count saturation on the 4-bit instance
      restart();
      drive(0, 0);
      for (int k = 0; k < 20; k++) drive(1, fibv[k][31:0]);
      drive(0, 0);
      settle();
      chk("t5_matches_b", mcnt[1], 20);
      chk("t5_cnt_b", b_cnt, 15);
      chk("t5_cnt_a", a_cnt, 20);

      // reset while in FAIL with valid high
      restart();
      drive(0, 0);
      drive(1, 1); drive(1, 1); drive(1, 7); drive(1, 9);
      drive(1, 5, 0, 1);
      settle();
      chk("t6_err", a_err, 0);
      chk("t6_ee", a_ee, 0);
      chk("t6_er", a_er, 0);
      chk("t6_cnt", a_cnt, 0);
      mcnt[0] = 0;
      drive(1, 1);
      drive(1, 1); drive(1, 1); drive(1, 2);
      drive(0, 0);
      settle();
      chk("t6_matches", mcnt[0], 3);

      // randomized traffic
      restart();
      for (int c = 0; c < 400; c++) begin
         idx = mfail[0] ? mn[1] : mn[0];
         d   = fibv[idx][31:0];
         if ($urandom_range(15) == 0) d = $urandom;
         clr = ($urandom_range(49) == 0) || mn[0] > 70 || mn[1] > 70;
         drive($urandom_range(3) != 0, d, clr, 0);
      end
      drive(0, 0);
      settle();
      chk("queue_a_empty", qa.size(), 0);
      chk("queue_b_empty", qb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
